tx_pattern_gen: RTL

Transmit bit-pattern source directly upstream of the TX driver. Each enabled `clk` cycle it produces one registered bit on `out`, which connects straight to the driver's bit input. Supported sources are selectable PRBS polynomials, a repeating user pattern, a clock pattern and constants. It also provides single-bit error injection and a saturating bit counter, so the emulated receiver's checker can be exercised end to end.

---
 rtl/tx_pattern_gen_pkg.sv | 52 +++++
 rtl/tx_pattern_gen_lfsr.sv | 51 +++++
 rtl/tx_pattern_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/tx_pattern_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_pattern_package : mode encodings, PRBS polynomial constants and the
//                      LFSR lock-up guard shared by the pattern generator.
// Revision: 1.0
// ---------------------------------------------------------------------------
package tx_pattern_package;

    typedef enum logic [2:0] {
        MODE_PRBS7  = 3'd0,
        MODE_PRBS9  = 3'd1,
        MODE_PRBS15 = 3'd2,
        MODE_PRBS31 = 3'd3,
        MODE_USER   = 3'd4,
        MODE_CLOCK  = 3'd5,
        MODE_ZERO   = 3'd6,
        MODE_ONE    = 3'd7
    } tx_mode_t;

    localparam int LFSR_MAX_W = 31;
    localparam logic [LFSR_MAX_W-1:0] LFSR_ALL_ONES = 31'h7FFF_FFFF;

    localparam int PRBS7_N  = 7;
    localparam int PRBS7_T  = 6;
    localparam int PRBS9_N  = 9;
    localparam int PRBS9_T  = 5;
    localparam int PRBS15_N = 15;
    localparam int PRBS15_T = 14;
    localparam int PRBS31_N = 31;
    localparam int PRBS31_T = 28;

    // Active-bit mask of the LFSR for a mode; zero for non-PRBS modes.
    function automatic logic [LFSR_MAX_W-1:0] prbs_mask(input tx_mode_t m);
        case (m)
            MODE_PRBS7:  return LFSR_ALL_ONES >> (LFSR_MAX_W - PRBS7_N);
            MODE_PRBS9:  return LFSR_ALL_ONES >> (LFSR_MAX_W - PRBS9_N);
            MODE_PRBS15: return LFSR_ALL_ONES >> (LFSR_MAX_W - PRBS15_N);
            MODE_PRBS31: return LFSR_ALL_ONES;
            default:     return '0;
        endcase
    endfunction

    // An all-zero active field would lock the LFSR; force it to all ones.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_guard(input logic [LFSR_MAX_W-1:0] v,
                                                          input tx_mode_t m);
        logic [LFSR_MAX_W-1:0] mask;
        mask = prbs_mask(m);
        return ((v & mask) == '0) ? (v | mask) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_pattern_gen_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prbs_lfsr : combinational Fibonacci LFSR next-state for the selected PRBS
//             polynomial, with the all-zero lock-up guard applied first.
// Revision: 1.0
// ---------------------------------------------------------------------------
module prbs_lfsr
    import tx_pattern_package::*;
(
    input  logic [30:0] lfsr,
    input  logic [2:0]  mode,
    output logic [30:0] lfsr_next,
    output logic        new_bit
);

    tx_mode_t    mode_sel;
    logic [30:0] seeded;

    assign mode_sel = tx_mode_t'(mode);

    always_comb begin
        seeded    = lfsr_guard(lfsr, mode_sel);
        lfsr_next = seeded;
        new_bit   = 1'b0;
        // Bits above N-1 pass through untouched in every PRBS mode.
        case (mode_sel)
            MODE_PRBS7: begin
                new_bit   = seeded[PRBS7_N-1] ^ seeded[PRBS7_T-1];
                lfsr_next = {seeded[LFSR_MAX_W-1:PRBS7_N], seeded[PRBS7_N-2:0], new_bit};
            end
            MODE_PRBS9: begin
                new_bit   = seeded[PRBS9_N-1] ^ seeded[PRBS9_T-1];
                lfsr_next = {seeded[LFSR_MAX_W-1:PRBS9_N], seeded[PRBS9_N-2:0], new_bit};
            end
            MODE_PRBS15: begin
                new_bit   = seeded[PRBS15_N-1] ^ seeded[PRBS15_T-1];
                lfsr_next = {seeded[LFSR_MAX_W-1:PRBS15_N], seeded[PRBS15_N-2:0], new_bit};
            end
            MODE_PRBS31: begin
                new_bit   = seeded[PRBS31_N-1] ^ seeded[PRBS31_T-1];
                lfsr_next = {seeded[PRBS31_N-2:0], new_bit};
            end
            default: begin
                lfsr_next = lfsr;
                new_bit   = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tx_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tx_pattern_gen : registered TX bit source (PRBS / user / clock / constant)
//                  with single-bit error injection and a saturating counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tx_pattern_gen
    import tx_pattern_package::*;
#(
    parameter int PAT_WIDTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2:0]           mode,
    input  logic                 load,
    input  logic [30:0]          seed,
    input  logic [PAT_WIDTH-1:0] pattern,
    input  logic                 inj_err,
    output logic                 out,
    output logic                 inj_done,
    output logic [CNT_WIDTH-1:0] bit_count
);

    localparam int PTR_W = $clog2(PAT_WIDTH);

    tx_mode_t             mode_sel;
    logic [30:0]          prbs_next;
    logic                 prbs_bit;
    logic                 gen_bit;

    logic [30:0]          lfsr_q,      lfsr_d;
    logic [PTR_W-1:0]     ptr_q,       ptr_d;
    logic                 phase_q,     phase_d;
    logic                 pend_q,      pend_d;
    logic                 out_q,       out_d;
    logic                 inj_done_q,  inj_done_d;
    logic [CNT_WIDTH-1:0] bit_count_q, bit_count_d;

    assign mode_sel = tx_mode_t'(mode);

    prbs_lfsr u_prbs_lfsr (
        .lfsr      (lfsr_q),
        .mode      (mode),
        .lfsr_next (prbs_next),
        .new_bit   (prbs_bit)
    );

    always_comb begin
        lfsr_d      = lfsr_q;
        ptr_d       = ptr_q;
        phase_d     = phase_q;
        out_d       = out_q;
        bit_count_d = bit_count_q;
        inj_done_d  = 1'b0;
        gen_bit     = 1'b0;
        // Requests arriving while one is pending simply merge into it.
        pend_d      = pend_q | inj_err;

        if (load) begin
            lfsr_d      = lfsr_guard(seed, mode_sel);
            ptr_d       = '0;
            phase_d     = 1'b1;
            bit_count_d = '0;
        end else if (en) begin
            case (mode_sel)
                MODE_PRBS7, MODE_PRBS9, MODE_PRBS15, MODE_PRBS31: begin
                    gen_bit = prbs_bit;
                    lfsr_d  = prbs_next;
                end
                MODE_USER: begin
                    gen_bit = pattern[ptr_q];
                    ptr_d   = (ptr_q == PTR_W'(PAT_WIDTH - 1)) ? '0 : ptr_q + PTR_W'(1);
                end
                MODE_CLOCK: begin
                    gen_bit = phase_q;
                    phase_d = ~phase_q;
                end
                MODE_ZERO: gen_bit = 1'b0;
                default:   gen_bit = 1'b1;
            endcase
            // Inversion only touches the output; generator state is unaffected.
            out_d      = gen_bit ^ pend_q;
            inj_done_d = pend_q;
            pend_d     = inj_err;
            if (bit_count_q != '1) begin
                bit_count_d = bit_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= LFSR_ALL_ONES;
            ptr_q       <= '0;
            phase_q     <= 1'b1;
            pend_q      <= 1'b0;
            out_q       <= 1'b0;
            inj_done_q  <= 1'b0;
            bit_count_q <= '0;
        end else begin
            lfsr_q      <= lfsr_d;
            ptr_q       <= ptr_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            inj_done_q  <= inj_done_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign out       = out_q;
    assign inj_done  = inj_done_q;
    assign bit_count = bit_count_q;

endmodule
`default_nettype wire
